// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct_pkg
// Description : Shared constants and types for the 16-point DCT frame
//               scheduler: coefficient geometry, serializer beat count and
//               the core-tracking FSM state encoding.
// Contents    : N_COEF, COEF_W, RES_W, BEATS constants
//               core_state_e  {CORE_IDLE, CORE_RUN}
//               clog2_min1()  counter/pointer width helper (never 0 bits)
// Revision    : 1.0  initial release
// ============================================================================
package dct_pkg;

  localparam int N_COEF = 16;              // coefficients per frame
  localparam int COEF_W = 18;              // bits per coefficient
  localparam int RES_W  = N_COEF * COEF_W; // packed result vector (288)
  localparam int BEATS  = 8;               // serializer beats per frame

  // Tracks whether a frame is currently inside the DCT core.
  typedef enum logic [0:0] {
    CORE_IDLE = 1'b0,
    CORE_RUN  = 1'b1
  } core_state_e;

  // $clog2 returns 0 for 1, which would produce zero-width vectors for
  // degenerate parameter choices; clamp to at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dct_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dct_frame_scheduler_if
// Description : Bundles the frame-source handshake, the DCT core start/done
//               link and the serializer dispatch bus of the frame scheduler.
// Signals     : src_valid / src_ready          frame source handshake
//               core_start / core_done          DCT core launch / completion
//               core_result                     packed coefficients from core
//               ser_data_valid                  dispatch pulse to serializer
//               ser_results_flat                coefficients to serializer
// Modports    : master  - the scheduler
//               slave   - the surrounding environment (source, core, serializer)
// Revision    : 1.0  initial release
// ============================================================================
interface dct_frame_scheduler_if
  import dct_pkg::*;
#(
  parameter int RES_W = dct_pkg::RES_W
) ();

  logic             src_valid;
  logic             src_ready;
  logic             core_start;
  logic             core_done;
  logic [RES_W-1:0] core_result;
  logic             ser_data_valid;
  logic [RES_W-1:0] ser_results_flat;

  modport master (
    input  src_valid,
    input  core_done,
    input  core_result,
    output src_ready,
    output core_start,
    output ser_data_valid,
    output ser_results_flat
  );

  modport slave (
    output src_valid,
    output core_done,
    output core_result,
    input  src_ready,
    input  core_start,
    input  ser_data_valid,
    input  ser_results_flat
  );

endinterface
`default_nettype wire

// File: rtl/dct_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dct_result_fifo
// Description : DEPTH-entry FIFO holding finished DCT coefficient vectors
//               until the serializer can take them. Wrapping read/write
//               pointers plus an occupancy count. Push and pop in the same
//               cycle are allowed at any occupancy. No bypass: a pushed word
//               is visible at head no earlier than the following cycle.
// Ports       : clk        in   clock
//               reset_n    in   asynchronous active-low reset (empties FIFO)
//               push       in   write push_data at tail
//               push_data  in   WIDTH-bit word
//               pop        in   discard head entry
//               head       out  oldest entry (valid while count != 0)
//               count      out  current occupancy
// Revision    : 1.0  initial release
// ============================================================================
module dct_result_fifo
  import dct_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = dct_pkg::RES_W
) (
  input  wire logic                         clk,
  input  wire logic                         reset_n,
  input  wire logic                         push,
  input  wire logic [WIDTH-1:0]             push_data,
  input  wire logic                         pop,
  output logic      [WIDTH-1:0]             head,
  output logic      [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A pop frees the slot this cycle, so a push into a full FIFO is still
  // accepted when it coincides with a pop.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);

  assign head = mem[rd_ptr];

  // Storage is not reset; emptiness is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dct_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dct_frame_scheduler
// Description : Admits one 16-point DCT frame at a time into the DCT core,
//               buffers finished coefficient vectors and dispatches them to
//               the 8-beat output serializer without collisions. A core
//               watchdog abandons frames whose done never arrives.
// Ports       : clk            in   clock, rising edge
//               reset_n        in   asynchronous active-low reset
//               enable         in   1 = admit new frames; 0 = drain only
//               bus            if   master modport: src_valid/src_ready,
//                                   core_start/core_done/core_result,
//                                   ser_data_valid/ser_results_flat
//               busy           out  core in flight, buffer occupied or
//                                   serializer beats remaining
//               frames_done    out  dispatched-frame count (wraps)
//               err_timeout    out  sticky: core_done missed its window
//               err_spurious   out  sticky: core_done with no frame in flight
// Revision    : 1.0  initial release
// ============================================================================
module dct_frame_scheduler
  import dct_pkg::*;
#(
  parameter int N_COEF  = dct_pkg::N_COEF,
  parameter int COEF_W  = dct_pkg::COEF_W,
  parameter int BEATS   = dct_pkg::BEATS,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 enable,
  dct_frame_scheduler_if.master     bus,
  output logic                      busy,
  output logic      [CNT_W-1:0]     frames_done,
  output logic                      err_timeout,
  output logic                      err_spurious
);

  localparam int RES_W  = N_COEF * COEF_W;
  localparam int WD_W   = clog2_min1(TIMEOUT);
  localparam int BC_W   = clog2_min1(BEATS + 1);
  localparam int FCNT_W = $clog2(DEPTH + 1);

  core_state_e       state;
  core_state_e       state_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic [BC_W-1:0]   beat_cnt;

  logic              launch;
  logic              push;
  logic              wd_expired;
  logic              spurious;
  logic              wd_at_limit;
  logic              dispatch;

  logic [FCNT_W-1:0] fifo_count;
  logic [RES_W-1:0]  fifo_head;

  // --------------------------------------------------------------------------
  // Result buffer
  // --------------------------------------------------------------------------
  dct_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_result_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (bus.core_result),
    .pop       (dispatch),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // --------------------------------------------------------------------------
  // Core FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CORE_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign wd_at_limit = (wd_cnt == WD_W'(TIMEOUT - 1));

  // --------------------------------------------------------------------------
  // Core FSM: next state and admission
  // A launch reserves the core and one free buffer entry, so the eventual
  // push of this frame's result can never find the buffer full.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    bus.src_ready = 1'b0;
    launch        = 1'b0;
    push          = 1'b0;
    wd_expired    = 1'b0;
    spurious      = 1'b0;

    bus.src_ready = enable && (state == CORE_IDLE) && (fifo_count < FCNT_W'(DEPTH));
    launch        = bus.src_valid && bus.src_ready;

    case (state)
      CORE_IDLE: begin
        // Includes a late done for a frame the watchdog already abandoned.
        spurious = bus.core_done;
        if (launch) begin
          state_nxt = CORE_RUN;
        end
      end
      CORE_RUN: begin
        // A done on the last permitted cycle still wins over the watchdog.
        if (bus.core_done) begin
          push      = 1'b1;
          state_nxt = CORE_IDLE;
        end else if (wd_at_limit) begin
          wd_expired = 1'b1;
          state_nxt  = CORE_IDLE;
        end
      end
      default: begin
        state_nxt = CORE_IDLE;
      end
    endcase
  end

  assign bus.core_start = launch;

  // --------------------------------------------------------------------------
  // Watchdog: counts cycles spent in CORE_RUN since the launch.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (launch) begin
      wd_cnt <= '0;
    end else if ((state == CORE_RUN) && !wd_at_limit) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Dispatch and serializer beat tracking.
  // Dispatch is permitted on the serializer's last beat (beat_cnt == 1) so
  // the next frame's first beat follows with no idle beat in between.
  // --------------------------------------------------------------------------
  assign dispatch = (fifo_count != '0) && (beat_cnt <= BC_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ser_data_valid   <= 1'b0;
      bus.ser_results_flat <= '0;
      beat_cnt             <= '0;
      frames_done          <= '0;
    end else if (dispatch) begin
      bus.ser_data_valid   <= 1'b1;
      bus.ser_results_flat <= fifo_head;
      beat_cnt             <= BC_W'(BEATS);
      frames_done          <= frames_done + CNT_W'(1);
    end else begin
      bus.ser_data_valid <= 1'b0;
      if (beat_cnt != '0) begin
        beat_cnt <= beat_cnt - BC_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (wd_expired) begin
        err_timeout <= 1'b1;
      end
      if (spurious) begin
        err_spurious <= 1'b1;
      end
    end
  end

  assign busy = (state == CORE_RUN) || (fifo_count != '0) || (beat_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_dct_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_frame_scheduler
// Description : Self-checking bench for dct_frame_scheduler. A small core
//               model answers each launch after a programmable latency with a
//               known coefficient vector; dispatched vectors are compared in
//               launch order against a queue of expected results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dct_frame_scheduler;
  import dct_pkg::*;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] frames_done;
  logic             err_timeout;
  logic             err_spurious;

  dct_frame_scheduler_if #(.RES_W(RES_W)) bus ();

  dct_frame_scheduler #(
    .N_COEF  (N_COEF),
    .COEF_W  (COEF_W),
    .BEATS   (BEATS),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .bus          (bus),
    .busy         (busy),
    .frames_done  (frames_done),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  // Single-frame vectors: delays are counted in cycles from the launch cycle.
  typedef struct {
    int lat;           // core latency, launch cycle -> done cycle
    int exp_valid_dly; // launch cycle -> cycle ser_data_valid observed
    int exp_frames;    // frames_done after this frame
    int exp_idle_dly;  // launch cycle -> first cycle busy is low
  } vec_t;

  vec_t             tbl [4];
  logic [RES_W-1:0] exp_q [$];
  logic [RES_W-1:0] fl_res;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   launch_id = 0;
  int   core_lat = 0;
  int   cd = 0;
  int   n_valid = 0;
  int   valid_cyc = -1;
  int   prev_vc = -1;
  int   launch_cyc = 0;
  int   occ = 0;
  int   saw_full = 0;
  int   t0, base_l, base_v;
  logic in_flight = 1'b0;
  logic prev_done = 1'b0;
  logic chk_ready = 1'b0;
  logic chk_gap = 1'b0;
  logic inj_done = 1'b0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_v(input string nm, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame 0 has coef i = i; frame 1 is all ones; others a spread pattern.
  function automatic logic [RES_W-1:0] gen_res(input int id);
    logic [RES_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_COEF; i++) begin
      if (id == 1) r[i*COEF_W +: COEF_W] = '1;
      else         r[i*COEF_W +: COEF_W] = COEF_W'(i + id * 32'h12B3D);
    end
    return r;
  endfunction

  // One clock cycle: observe registered outputs, play the core, drive inputs.
  task automatic step(input logic sv, input logic en);
    @(negedge clk);
    cyc++;
    if (prev_done && in_flight) begin
      occ++;
      in_flight = 1'b0;
    end
    if (bus.ser_data_valid) begin
      n_valid++;
      if (occ > 0) occ--;
      if (exp_q.size() == 0) chk_b("unexpected_dispatch", 1'b1, 1'b0);
      else                   chk_v("result_order", bus.ser_results_flat, exp_q.pop_front());
      if (chk_gap && prev_vc >= 0) chk_i("dispatch_spacing", cyc - prev_vc, 8);
      prev_vc   = cyc;
      valid_cyc = cyc;
    end
    bus.core_done = 1'b0;
    prev_done     = 1'b0;
    if (inj_done) begin
      bus.core_done   = 1'b1;
      bus.core_result = gen_res(99);
      inj_done        = 1'b0;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.core_done   = 1'b1;
        bus.core_result = fl_res;
        prev_done       = 1'b1;
      end
    end
    bus.src_valid = sv;
    enable        = en;
    #1;
    if (chk_ready) begin
      if (occ >= DEPTH) saw_full++;
      chk_b("src_ready", bus.src_ready, en && !in_flight && (occ < DEPTH));
    end
    if (!en) begin
      chk_b("no_start_disabled", bus.core_start, 1'b0);
      chk_b("src_ready_disabled", bus.src_ready, 1'b0);
    end
    if (bus.core_start) begin
      launch_cyc = cyc;
      fl_res     = gen_res(launch_id);
      launch_id++;
      in_flight  = 1'b1;
      if (core_lat > 0) begin
        cd = core_lat;
        exp_q.push_back(fl_res);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    tbl[0] = '{lat: 5,  exp_valid_dly: 7,  exp_frames: 1, exp_idle_dly: 15};
    tbl[1] = '{lat: 1,  exp_valid_dly: 3,  exp_frames: 2, exp_idle_dly: 11};
    tbl[2] = '{lat: 10, exp_valid_dly: 12, exp_frames: 3, exp_idle_dly: 20};
    tbl[3] = '{lat: 64, exp_valid_dly: 66, exp_frames: 4, exp_idle_dly: 74};

    bus.src_valid   = 1'b0;
    bus.core_done   = 1'b0;
    bus.core_result = '0;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    chk_b("rst_ser_valid", bus.ser_data_valid, 1'b0);
    chk_v("rst_ser_flat", bus.ser_results_flat, '0);
    chk_i("rst_frames_done", int'(frames_done), 0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_err_timeout", err_timeout, 1'b0);
    chk_b("rst_err_spurious", err_spurious, 1'b0);
    chk_b("rst_src_ready", bus.src_ready, 1'b0);
    reset_n = 1'b1;

    // ---------------- single frames (table) ----------------
    for (int v = 0; v < 4; v++) begin
      core_lat = tbl[v].lat;
      step(1'b1, 1'b1);
      chk_b("launch", bus.core_start, 1'b1);
      t0     = launch_cyc;
      base_v = n_valid;
      for (int k = 0; k < 200 && n_valid == base_v; k++) step(1'b0, 1'b1);
      chk_i("dispatch_seen", n_valid - base_v, 1);
      chk_i("valid_delay", valid_cyc - t0, tbl[v].exp_valid_dly);
      chk_i("frames_done", int'(frames_done), tbl[v].exp_frames);
      chk_b("busy_during_beats", busy, 1'b1);
      for (int k = 0; k < 100 && busy; k++) step(1'b0, 1'b1);
      chk_i("busy_fall", cyc - t0, tbl[v].exp_idle_dly);
    end

    // ---------------- back-to-back, latency 3 ----------------
    core_lat = 3;
    chk_gap  = 1'b1;
    prev_vc  = -1;
    base_l   = launch_id;
    base_v   = n_valid;
    for (int k = 0; k < 300; k++) begin
      step(launch_id - base_l < 4, 1'b1);
      if (n_valid - base_v == 4 && !busy) break;
    end
    chk_i("b2b_dispatches", n_valid - base_v, 4);
    chk_i("b2b_frames_done", int'(frames_done), 8);
    chk_i("b2b_queue_empty", exp_q.size(), 0);

    // ---------------- backpressure, latency 1 ----------------
    core_lat  = 1;
    chk_ready = 1'b1;
    prev_vc   = -1;
    occ       = 0;
    base_l    = launch_id;
    base_v    = n_valid;
    for (int k = 0; k < 300; k++) begin
      step(launch_id - base_l < 6, 1'b1);
      if (n_valid - base_v == 6 && !busy) break;
    end
    chk_b("bp_full_seen", saw_full > 0, 1'b1);
    chk_i("bp_dispatches", n_valid - base_v, 6);
    chk_i("bp_frames_done", int'(frames_done), 14);
    chk_i("bp_queue_empty", exp_q.size(), 0);
    chk_ready = 1'b0;
    chk_gap   = 1'b0;

    // ---------------- watchdog timeout and late done ----------------
    core_lat = 0;
    step(1'b1, 1'b1);
    chk_b("to_launch", bus.core_start, 1'b1);
    t0 = launch_cyc;
    for (int k = 0; k < 63; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_i("to_cycle", cyc - t0, 64);
    chk_b("to_not_yet", err_timeout, 1'b0);
    chk_b("to_busy_running", busy, 1'b1);
    step(1'b0, 1'b1);
    chk_b("to_err_set", err_timeout, 1'b1);
    chk_b("to_idle", busy, 1'b0);
    chk_b("to_ready_again", bus.src_ready, 1'b1);
    in_flight = 1'b0;
    base_v    = n_valid;
    inj_done  = 1'b1;
    step(1'b0, 1'b1);
    chk_b("sp_not_yet", err_spurious, 1'b0);
    step(1'b0, 1'b1);
    chk_b("sp_err_set", err_spurious, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    chk_i("sp_no_dispatch", n_valid - base_v, 0);
    chk_b("sp_busy", busy, 1'b0);
    chk_i("sp_frames_done", int'(frames_done), 14);
    core_lat = 2;
    step(1'b1, 1'b1);
    chk_b("to_next_launch", bus.core_start, 1'b1);
    for (int k = 0; k < 50 && (n_valid == base_v || busy); k++) step(1'b0, 1'b1);
    chk_i("to_next_dispatch", n_valid - base_v, 1);
    chk_i("to_next_frames_done", int'(frames_done), 15);
    chk_b("to_err_sticky", err_timeout, 1'b1);

    // ---------------- enable drop with one in flight, one buffered ----------------
    base_l = launch_id;
    base_v = n_valid;
    for (int k = 0; k < 200; k++) begin
      core_lat = (launch_id - base_l < 2) ? 2 : 5;
      step(1'b1, launch_id - base_l < 3);
      if (launch_id - base_l == 3 && n_valid - base_v == 3 && !busy) break;
    end
    chk_i("drain_launches", launch_id - base_l, 3);
    chk_i("drain_dispatches", n_valid - base_v, 3);
    chk_i("drain_frames_done", int'(frames_done), 18);
    chk_b("drain_busy_low", busy, 1'b0);

    // ---------------- reset mid-serialization ----------------
    core_lat = 4;
    base_l   = launch_id;
    for (int k = 0; k < 12; k++) step(launch_id - base_l < 2, 1'b1);
    chk_i("pre_rst_frames_done", int'(frames_done), 19);
    chk_b("pre_rst_busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_b("mid_rst_ser_valid", bus.ser_data_valid, 1'b0);
    chk_v("mid_rst_ser_flat", bus.ser_results_flat, '0);
    chk_i("mid_rst_frames_done", int'(frames_done), 0);
    chk_b("mid_rst_busy", busy, 1'b0);
    chk_b("mid_rst_err_timeout", err_timeout, 1'b0);
    chk_b("mid_rst_err_spurious", err_spurious, 1'b0);
    chk_b("mid_rst_core_start", bus.core_start, 1'b0);
    bus.core_done = 1'b0;
    exp_q.delete();
    cd        = 0;
    in_flight = 1'b0;
    prev_done = 1'b0;
    occ       = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    base_v  = n_valid;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
    chk_i("post_rst_no_dispatch", n_valid - base_v, 0);
    chk_b("post_rst_busy", busy, 1'b0);
    chk_i("post_rst_frames_done", int'(frames_done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
